// File: rtl/serial_alu_if.sv
// serial_alu_if: request/response bundle for the bit-serial ALU.
// Optional overflow flag is present when SERIAL_ALU_OVF_EN is defined.
interface serial_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       aluctr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             e;
    logic             z;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, cin, aluctr,
        input  busy, done, d, e, z, ovf
    );

    modport slave (
        input  start, a, b, cin, aluctr,
        output busy, done, d, e, z, ovf
    );
`else
    modport master (
        output start, a, b, cin, aluctr,
        input  busy, done, d, e, z
    );

    modport slave (
        input  start, a, b, cin, aluctr,
        output busy, done, d, e, z
    );
`endif
endinterface

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU running WIDTH-bit operands through one 1-bit
// slice (ADD/AND/NOR/XOR), LSB first, with a start/busy/done handshake.
// Optional feature: define SERIAL_ALU_OVF_EN to add the signed-overflow
// output ovf on the interface.
module serial_alu #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    serial_alu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_NOR = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    op_t              op;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             last_bit;
    logic             bit_res;
    logic             bit_cout;
    logic [WIDTH-1:0] result_full;

    logic [WIDTH-1:0] d_r;
    logic             e_r;
    logic             z_r;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf_r;
`endif

    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
    assign result_full = {bit_res, r_sh[WIDTH-1:1]};

    // State register; reset is synchronous so it wins over a same-cycle start.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; start is only honoured in IDLE/DONE.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The shared 1-bit slice operating on the current LSBs.
    always_comb begin
        bit_res  = 1'b0;
        bit_cout = 1'b0;
        case (op)
            OP_ADD: begin
                bit_res  = a_sh[0] ^ b_sh[0] ^ carry;
                bit_cout = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
            end
            OP_AND:  bit_res = a_sh[0] & b_sh[0];
            OP_NOR:  bit_res = ~(a_sh[0] | b_sh[0]);
            OP_XOR:  bit_res = a_sh[0] ^ b_sh[0];
            default: bit_res = 1'b0;
        endcase
    end

    // Operand capture, per-bit shifting, and result publication on the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            op    <= OP_ADD;
            carry <= 1'b0;
            cnt   <= '0;
            d_r   <= '0;
            e_r   <= 1'b0;
            z_r   <= 1'b1;
`ifdef SERIAL_ALU_OVF_EN
            ovf_r <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            r_sh  <= '0;
            op    <= op_t'(bus.aluctr);
            // cin only matters for ADD; other ops start with a clear carry.
            carry <= (bus.aluctr == 2'b00) ? bus.cin : 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= result_full;
            carry <= bit_cout;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                d_r <= result_full;
                e_r <= (op == OP_ADD) ? bit_cout : 1'b0;
                z_r <= (result_full == '0);
`ifdef SERIAL_ALU_OVF_EN
                // carry still holds the carry into the MSB at this edge.
                ovf_r <= (op == OP_ADD) ? (carry ^ bit_cout) : 1'b0;
`endif
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.d    = d_r;
    assign bus.e    = e_r;
    assign bus.z    = z_r;
`ifdef SERIAL_ALU_OVF_EN
    assign bus.ovf  = ovf_r;
`endif

endmodule
